// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the multi-port register file:
// read ports, write ports, issue tracking and flush.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;

    modport master (
        output ra, we, wa, wd, iss_valid, iss_rd, flush,
        input  rd, rbusy
    );

    modport slave (
        input  ra, we, wa, wd, iss_valid, iss_rd, flush,
        output rd, rbusy
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional write-to-read
// bypass, hardwired zero register and a per-register busy scoreboard.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_d;
    logic [NRD*XLEN-1:0] rd_c;
    logic [NRD-1:0]      rbusy_c;

    // Later write ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            for (int j = 0; j < NWR; j++) begin
                if (bus.we[j] && (bus.wa[j*AW +: AW] == AW'(r))) begin
                    regs_d[r] = bus.wd[j*XLEN +: XLEN];
                end
            end
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
        end
    end

    // Per-bit priority: issue set beats flush, flush beats writeback clear.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.we[j] && (bus.wa[j*AW +: AW] == AW'(r))) begin
                    busy_d[r] = 1'b0;
                end
            end
            if (bus.flush) begin
                busy_d[r] = 1'b0;
            end
            if (bus.iss_valid && (bus.iss_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    // Reads are combinational; reset masks them so bypassed write data
    // cannot leak out while the file is being cleared.
    always_comb begin
        rd_c    = '0;
        rbusy_c = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_c[i*XLEN +: XLEN] = regs_q[bus.ra[i*AW +: AW]];
            rbusy_c[i]           = busy_q[bus.ra[i*AW +: AW]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (bus.we[j] && (bus.wa[j*AW +: AW] == bus.ra[i*AW +: AW])) begin
                        rd_c[i*XLEN +: XLEN] = bus.wd[j*XLEN +: XLEN];
                        rbusy_c[i]           = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (bus.ra[i*AW +: AW] == '0)) begin
                rd_c[i*XLEN +: XLEN] = '0;
                rbusy_c[i]           = 1'b0;
            end
        end
        if (reset) begin
            rd_c    = '0;
            rbusy_c = '0;
        end
    end

    assign bus.rd    = rd_c;
    assign bus.rbusy = rbusy_c;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a bypass and a non-bypass build share one stimulus
// stream; directed table, async-reset sequence, then random vs. a model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  we = '0;
    logic [9:0]  wa = '0;
    logic [63:0] wd = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        flush = 1'b0;
    logic [9:0]  ra = '0;
    logic [63:0] rd_b, rd_n;
    logic [1:0]  rbusy_b, rbusy_n;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mreg  [32];
    logic        mbusy [32];

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifb ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifn ();

    assign ifb.ra = ra;  assign ifb.we = we;  assign ifb.wa = wa;  assign ifb.wd = wd;
    assign ifb.iss_valid = iss_valid;  assign ifb.iss_rd = iss_rd;  assign ifb.flush = flush;
    assign ifn.ra = ra;  assign ifn.we = we;  assign ifn.wa = wa;  assign ifn.wd = wd;
    assign ifn.iss_valid = iss_valid;  assign ifn.iss_rd = iss_rd;  assign ifn.flush = flush;
    assign rd_b = ifb.rd;  assign rbusy_b = ifb.rbusy;
    assign rd_n = ifn.rd;  assign rbusy_n = ifn.rbusy;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1))
        u_byp (.clk(clk), .reset(reset), .bus(ifb));
    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1))
        u_nobyp (.clk(clk), .reset(reset), .bus(ifn));

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iss;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  ra0, ra1;
        logic [31:0] b0, b1;
        logic [1:0]  bb;
        logic [31:0] n0, n1;
        logic [1:0]  nb;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic [1:0] w, logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] d0, logic [31:0] d1, logic is, logic [4:0] ir,
                                logic f, logic [4:0] r0, logic [4:0] r1,
                                logic [31:0] b0, logic [31:0] b1, logic [1:0] bb,
                                logic [31:0] n0, logic [31:0] n1, logic [1:0] nb);
        vec_t v;
        v.we = w; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1;
        v.iss = is; v.ird = ir; v.fl = f; v.ra0 = r0; v.ra1 = r1;
        v.b0 = b0; v.b1 = b1; v.bb = bb; v.n0 = n0; v.n1 = n1; v.nb = nb;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(logic [1:0] w, logic [4:0] a0, logic [4:0] a1,
                         logic [31:0] d0, logic [31:0] d1, logic is, logic [4:0] ir,
                         logic f, logic [4:0] r0, logic [4:0] r1);
        we = w; wa = {a1, a0}; wd = {d1, d0};
        iss_valid = is; iss_rd = ir; flush = f; ra = {r1, r0};
    endtask

    // Reference rules: reg 0 is zero, bypass takes the last matching write.
    function automatic logic [31:0] m_rd(int a, bit byp);
        logic [31:0] v;
        if (reset || a == 0) return 32'h0;
        v = mreg[a];
        if (byp) for (int j = 0; j < 2; j++)
            if (we[j] && int'(wa[j*5 +: 5]) == a) v = wd[j*32 +: 32];
        return v;
    endfunction

    function automatic logic m_busy(int a, bit byp);
        if (reset || a == 0) return 1'b0;
        if (byp) for (int j = 0; j < 2; j++)
            if (we[j] && int'(wa[j*5 +: 5]) == a) return 1'b0;
        return mbusy[a];
    endfunction

    task automatic model_update();
        if (reset) begin
            for (int r = 0; r < 32; r++) begin mreg[r] = 0; mbusy[r] = 0; end
            return;
        end
        for (int j = 0; j < 2; j++) if (we[j]) begin
            if (wa[j*5 +: 5] != 0) mreg[wa[j*5 +: 5]] = wd[j*32 +: 32];
            mbusy[wa[j*5 +: 5]] = 1'b0;
        end
        if (flush) for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
        if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model(string tag);
        for (int i = 0; i < 2; i++) begin
            int a = int'(ra[i*5 +: 5]);
            chk({tag, "_rd_byp"},   rd_b[i*32 +: 32], m_rd(a, 1'b1));
            chk({tag, "_rd_nobyp"}, rd_n[i*32 +: 32], m_rd(a, 1'b0));
            chk({tag, "_busy_byp"},   {31'b0, rbusy_b[i]}, {31'b0, m_busy(a, 1'b1)});
            chk({tag, "_busy_nobyp"}, {31'b0, rbusy_n[i]}, {31'b0, m_busy(a, 1'b0)});
        end
    endtask

    localparam logic [31:0] D  = 32'hDEADBEEF;
    localparam logic [31:0] W1 = 32'h11111111;
    localparam logic [31:0] W2 = 32'h22222222;

    initial begin
        for (int r = 0; r < 32; r++) begin mreg[r] = 0; mbusy[r] = 0; end

        tbl[0]  = mk(2'b01, 5, 0, D, 0,            0, 0, 0, 0, 5,  0, D, 2'b00,   0, 0, 2'b00);
        tbl[1]  = mk(2'b00, 0, 0, 0, 0,            0, 0, 0, 5, 5,  D, D, 2'b00,   D, D, 2'b00);
        tbl[2]  = mk(2'b11, 7, 7, W1, W2,          0, 0, 0, 7, 7,  W2, W2, 2'b00, 0, 0, 2'b00);
        tbl[3]  = mk(2'b01, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 7, 0,  W2, 0, 2'b00,  W2, 0, 2'b00);
        tbl[4]  = mk(2'b00, 0, 0, 0, 0,            1, 3, 0, 3, 0,  0, 0, 2'b00,   0, 0, 2'b00);
        tbl[5]  = mk(2'b00, 0, 0, 0, 0,            0, 0, 0, 3, 0,  0, 0, 2'b01,   0, 0, 2'b01);
        tbl[6]  = tbl[5];
        tbl[7]  = tbl[5];
        tbl[8]  = mk(2'b01, 3, 0, 5, 0,            0, 0, 0, 3, 3,  5, 5, 2'b00,   0, 0, 2'b11);
        tbl[9]  = mk(2'b01, 3, 0, 6, 0,            1, 3, 0, 3, 3,  6, 6, 2'b00,   5, 5, 2'b00);
        tbl[10] = mk(2'b00, 0, 0, 0, 0,            0, 0, 0, 3, 3,  6, 6, 2'b11,   6, 6, 2'b11);
        tbl[11] = mk(2'b00, 0, 0, 0, 0,            1, 4, 0, 4, 9,  0, 0, 2'b00,   0, 0, 2'b00);
        tbl[12] = mk(2'b00, 0, 0, 0, 0,            1, 9, 0, 4, 9,  0, 0, 2'b01,   0, 0, 2'b01);
        tbl[13] = mk(2'b00, 0, 0, 0, 0,            0, 0, 1, 4, 9,  0, 0, 2'b11,   0, 0, 2'b11);
        tbl[14] = mk(2'b00, 0, 0, 0, 0,            0, 0, 0, 4, 9,  0, 0, 2'b00,   0, 0, 2'b00);
        tbl[15] = mk(2'b00, 0, 0, 0, 0,            1, 9, 0, 4, 9,  0, 0, 2'b00,   0, 0, 2'b00);
        tbl[16] = mk(2'b00, 0, 0, 0, 0,            1, 4, 1, 4, 9,  0, 0, 2'b10,   0, 0, 2'b10);
        tbl[17] = mk(2'b00, 0, 0, 0, 0,            0, 0, 0, 4, 9,  0, 0, 2'b01,   0, 0, 2'b01);
        tbl[18] = mk(2'b00, 0, 0, 0, 0,            1, 0, 0, 0, 3,  0, 6, 2'b00,   0, 6, 2'b00);
        tbl[19] = mk(2'b00, 0, 0, 0, 0,            0, 0, 0, 0, 3,  0, 6, 2'b00,   0, 6, 2'b00);

        // Reset held: every address reads 0 and not busy, even with writes pending.
        for (int a = 0; a < 32; a++) begin
            drive(2'b11, 5'(a), 5'(31 - a), 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 5'(a), 0, 5'(a), 5'(31 - a));
            #1;
            chk("rst_rd_byp",   rd_b[31:0],  32'h0);
            chk("rst_rd_nobyp", rd_n[63:32], 32'h0);
            chk("rst_busy",     {30'b0, rbusy_b}, 32'h0);
            chk("rst_busy_nb",  {30'b0, rbusy_n}, 32'h0);
            tick();
        end
        reset = 1'b0;

        for (int k = 0; k < 20; k++) begin
            drive(tbl[k].we, tbl[k].wa0, tbl[k].wa1, tbl[k].wd0, tbl[k].wd1,
                  tbl[k].iss, tbl[k].ird, tbl[k].fl, tbl[k].ra0, tbl[k].ra1);
            #1;
            chk($sformatf("tbl%0d_rd0_byp", k),   rd_b[31:0],  tbl[k].b0);
            chk($sformatf("tbl%0d_rd1_byp", k),   rd_b[63:32], tbl[k].b1);
            chk($sformatf("tbl%0d_busy_byp", k),  {30'b0, rbusy_b}, {30'b0, tbl[k].bb});
            chk($sformatf("tbl%0d_rd0_nobyp", k), rd_n[31:0],  tbl[k].n0);
            chk($sformatf("tbl%0d_rd1_nobyp", k), rd_n[63:32], tbl[k].n1);
            chk($sformatf("tbl%0d_busy_nobyp", k), {30'b0, rbusy_n}, {30'b0, tbl[k].nb});
            check_model($sformatf("tbl%0d_model", k));
            tick();
        end

        // x10 written and issued on the same edge, then async reset mid-cycle.
        drive(2'b01, 10, 0, 32'hABCD, 0, 1, 10, 0, 10, 10);
        tick();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 10, 10);
        #1;
        chk("x10_rd_byp",     rd_b[31:0], 32'hABCD);
        chk("x10_rd_nobyp",   rd_n[31:0], 32'hABCD);
        chk("x10_busy_byp",   {30'b0, rbusy_b}, 32'h3);
        chk("x10_busy_nobyp", {30'b0, rbusy_n}, 32'h3);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_rd_byp",     rd_b[31:0], 32'h0);
        chk("async_rd_nobyp",   rd_n[31:0], 32'h0);
        chk("async_busy_byp",   {30'b0, rbusy_b}, 32'h0);
        chk("async_busy_nobyp", {30'b0, rbusy_n}, 32'h0);
        drive(2'b01, 10, 0, 32'h1234, 0, 1, 10, 0, 10, 10);
        tick();
        reset = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 10, 10);
        #1;
        chk("post_rst_rd_nobyp", rd_n[31:0], 32'h0);
        chk("post_rst_busy_nb",  {30'b0, rbusy_n}, 32'h0);
        drive(2'b01, 10, 0, 32'h55, 0, 0, 0, 0, 10, 10);
        tick();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 10, 10);
        #1;
        chk("first_wr_rd_nobyp", rd_n[31:0], 32'h55);
        check_model("post_rst_model");
        tick();

        // Random traffic over a narrow address window to force collisions.
        for (int c = 0; c < 1500; c++) begin
            drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            check_model("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the fixed 2-read/1-write file. It adds configurable register count, data width, read-port and write-port counts, optional same-cycle write-to-read bypass, a hardwired zero register, and an integrated per-register busy scoreboard that decode uses to detect RAW hazards. It sits between decode (read/issue) and writeback (write/clear).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = log2(NREGS)
- NRD, 2, number of read ports (≥1)
- NWR, 1, number of write ports (≥1)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- ra  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rbusy  out  NRD  scoreboard busy flag for the register addressed by port i
- we  in  NWR  write enables
- wa  in  NWR*AW  write addresses
- wd  in  NWR*XLEN  write data
- iss_valid  in  1  instruction issued with a destination register
- iss_rd  in  AW  destination register of issued instruction
- flush  in  1  clear all busy bits (pipeline flush)

## Operation
- Storage: NREGS × XLEN flops; scoreboard: NREGS busy bits.
- Reset (asserted): all registers ← 0, all busy bits ← 0, asynchronously; rd outputs read 0 and rbusy reads 0 while reset is held.
- Write: on rising edge, for each port j with we[j]=1, reg[wa[j]] ← wd[j]. Same address on multiple enabled ports: highest-index port wins. Address 0 with ZERO_REG=1: write dropped.
- Read (combinational): rd[i] = reg[ra[i]]. With BYPASS=1, if any enabled write port targets ra[i] this cycle, rd[i] = that port's wd (highest-index match). ra[i]=0 with ZERO_REG=1: rd[i]=0 regardless of writes.
- Scoreboard set: iss_valid=1 sets busy[iss_rd] on the edge (ignored for register 0 when ZERO_REG=1).
- Scoreboard clear: each enabled write clears busy[wa[j]] on the edge.
- flush=1 clears all busy bits on the edge.
- Priority per busy bit, same edge: set (issue) > flush > clear (write). A new issue to a register being written back leaves it busy.
- rbusy[i] = busy[ra[i]]; with BYPASS=1, forced 0 when an enabled write targets ra[i] this cycle. Register 0 always 0 when ZERO_REG=1.
- Out-of-range addresses impossible (NREGS power of two).

## Timing
- Read latency 0 (combinational from ra and stored state).
- Write-to-read latency: 1 edge (BYPASS=0), 0 cycles (BYPASS=1).
- Issue-to-busy: rbusy asserts in the cycle after the iss_valid edge.
- Writeback-to-not-busy: 0 cycles with BYPASS=1, 1 edge with BYPASS=0.
- Reset mid-operation: pending writes/issues in the reset cycle are discarded; state is 0 the cycle reset deasserts; first write takes effect on the first edge with reset low.

## Test plan
- Reset then read all ports at addresses 0..NREGS-1 -> every rd = 0, every rbusy = 0.
- Write port 0 x5 ← 0xDEADBEEF, read x5 on port 1 same cycle -> 0xDEADBEEF with BYPASS=1, 0x00000000 with BYPASS=0; next cycle 0xDEADBEEF in both builds.
- NWR=2: both ports write x7 (0x11111111 on port 0, 0x22222222 on port 1) -> x7 reads 0x22222222; write x0 ← 0xFFFFFFFF -> x0 reads 0.
- Issue x3, then three idle cycles -> rbusy for x3 = 1; write x3 ← 0x5 -> rbusy drops (same cycle BYPASS=1, next cycle BYPASS=0); issue x3 and write x3 on the same edge -> x3 remains busy.
- Issue x4 and x9 on consecutive cycles, assert flush -> both busy bits 0 next cycle; flush together with issue x4 -> x4 busy, x9 clear.
- Assert reset asynchronously mid-cycle while x10 holds 0xABCD and is busy -> rd=0 and rbusy=0 immediately, before next clock edge.
